mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface for the MIPS core.
- Accepts load/store requests from the core's MEM stage through a valid/ready handshake and drives mem_source, address and write data toward the data memory.
- Loads: samples the combinational read word, then performs byte-lane extraction and sign extension locally.
- Accesses that cross a word boundary are split into multiple memory cycles by a small FSM.

Parameters:
SPLIT_UNALIGNED, 1, 1: split word-crossing/unaligned accesses; 0: flag them as errors.
W, 32, data width; fixed at 32.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  4  loads: 0000 LW, 0001 LHU, 0010 LH, 0011 LBU, 0100 LB; stores: 1000 SW, 1001 SH, 1011 SB; all other codes illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  illegal op, or misaligned access with SPLIT_UNALIGNED=0
mem_source  out  4  memory command, using the `MEM_* macros from defined.vh; `MEM_NOP when idle
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data, right-aligned
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - All outputs are registered, except req_ready, which is decoded from the state register.
- Reset values:
  - req_ready=0 while rst is high, 1 in the first cycle after.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_source=`MEM_NOP, mem_addr=0, mem_wdata=0.
- States: IDLE, LD0, LD1, ST, RESP.
  - req_ready=1 only in IDLE.
  - Request is accepted when req_valid & req_ready; op, addr and wdata are latched.
- Offsets: o = addr[1:0]; size s = 4/2/1 bytes.
- Loads:
  - Always issue `MEM_READ32 to word address A = addr & ~3. Sub-word read codes are never used.
  - LD0 drives A; mem_rdata is captured at the end of LD0.
  - If o+s > 4 (word-crossing), LD1 drives (A+4) mod 2^32, captured likewise.
  - Merge is little-endian: byte k of the result = byte (o+k) of the concatenation {word1, word0}.
  - Zero-extend for LHU/LBU; sign-extend from bit 15 (LH) or bit 7 (LB).
  - A halfword at o=1 lies within one word and needs no second read.
- Stores:
  - Aligned cases use a single cycle in ST:
    - SW at o=0 uses `MEM_WRITE32.
    - SH at o even uses `MEM_WRITE16, with mem_wdata[15:0]=data.
    - SB uses `MEM_WRITE8.
  - Misaligned SW/SH with SPLIT_UNALIGNED=1: ST issues s consecutive `MEM_WRITE8 cycles.
    - Cycle i writes addr+i with mem_wdata[7:0] = data byte i.
    - Byte counter is 2 bits; addresses wrap mod 2^32.
- Misalignment when SPLIT_UNALIGNED=0:
  - Applies to any LW/SW with o≠0 and any LH/LHU/SH with o odd.
  - Result: no memory cycle, go straight to RESP with rsp_err=1.
- Illegal op: same handling as misalignment; mem_source stays `MEM_NOP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - mem_source=`MEM_NOP in RESP and IDLE.
  - There is no response back-pressure.
- Latency from the accept edge to rsp_valid:
  - Aligned load or store: 2 cycles.
  - Crossing load: 3 cycles.
  - Split SW: 5 cycles. Split SH: 3 cycles.
  - Error: 1 cycle.
- Reset mid-operation: returns to IDLE at that edge and mem_source=`MEM_NOP. Bytes already written are not rolled back, and no response is produced.
- req_valid while busy is ignored; the core holds the request until req_ready.

Test Plan:
Preload memory 0x10 = 0x44332211, 0x14 = 0x88776655 for all scenarios.
1. LW 0x10 -> one READ32 at 0x10; rsp_valid 2 cycles after accept; rsp_rdata=0x44332211, rsp_err=0.
2. LB 0x17 -> 0xFFFFFF88; LBU 0x17 -> 0x00000088; LH 0x16 -> 0xFFFF8877; LHU 0x11 -> 0x00003322 (single read).
3. SPLIT=1, LW 0x13 -> READ32 at 0x10 then 0x14; rsp_rdata=0x77665544 at 3 cycles.
4. SPLIT=1, SW 0x15 data 0xDEADBEEF -> WRITE8 at 0x15/0x16/0x17/0x18 with EF/BE/AD/DE. Afterwards word 0x14 = 0xADBEEF55 and byte 0x18 = 0xDE.
5. SPLIT=0, LH 0x11 -> rsp_err=1, rsp_rdata=0, no non-NOP mem_source. Op 0111 gives the same result.
6. rst asserted on the third cycle of scenario 4 (bytes 0x15, 0x16 written) -> mem_source NOP next cycle, no rsp_valid, req_ready=1 after release; byte 0x17 still 0x88.

Source files
------------

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the MIPS core's data-memory interface. It takes one
// load/store request at a time from the MEM stage and drives word reads or
// sized writes toward the data memory. For loads it samples whole words and
// does the byte-lane extraction and sign extension itself. An access that
// crosses a word boundary is broken into several memory cycles, or is
// rejected when SPLIT_UNALIGNED is 0.
//
// Parameters
//   SPLIT_UNALIGNED  1: split unaligned accesses, 0: report them as errors
//   W                data/address width, fixed at 32
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   unit can accept a request (IDLE only)
//   req_op      operation code (LW/LHU/LH/LBU/LB/SW/SH/SB)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   load result, 0 for stores and errors
//   rsp_err     illegal op, or misaligned access when not splitting
//   mem_source  memory command (`MEM_* codes), `MEM_NOP when idle
//   mem_addr    memory byte address
//   mem_wdata   memory write data, right-aligned
//   mem_rdata   combinational read data from memory
// ---------------------------------------------------------------------------

// Command codes normally come from defined.vh; these defaults apply only
// when that header has not been included first.
`ifndef MEM_NOP
`define MEM_NOP     4'h0
`endif
`ifndef MEM_READ8
`define MEM_READ8   4'h1
`endif
`ifndef MEM_READ16
`define MEM_READ16  4'h2
`endif
`ifndef MEM_READ32
`define MEM_READ32  4'h3
`endif
`ifndef MEM_WRITE8
`define MEM_WRITE8  4'h4
`endif
`ifndef MEM_WRITE16
`define MEM_WRITE16 4'h5
`endif
`ifndef MEM_WRITE32
`define MEM_WRITE32 4'h6
`endif

module mem_access_unit #(
    parameter int SPLIT_UNALIGNED = 1,
    parameter int W               = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [3:0]   mem_source,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_LHU = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0011;
    localparam logic [3:0] OP_LB  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SB  = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD0,
        S_LD1,
        S_ST,
        S_RESP
    } state_t;

    state_t       r_state;
    logic [3:0]   r_op;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic         r_cross;
    logic [1:0]   r_cnt;
    logic [1:0]   r_last;
    logic [W-1:0] r_word0;

    // Request decode (valid only while a request is presented).
    logic [1:0]     w_off;
    logic [2:0]     w_nbytes;
    logic           w_load;
    logic           w_legal;
    logic           w_misal;
    logic           w_cross;
    logic           w_err;
    logic           w_accept;
    logic [3:0]     w_st_src;
    logic [W-1:0]   w_st_data;

    // Load merge.
    logic [2*W-1:0] w_cat;
    logic [2*W-1:0] w_shifted;
    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_ld;

    // Split-store stepping.
    logic [1:0]     w_cnt_nxt;
    logic [7:0]     w_byte_nxt;

    // Held low during reset so the core never sees a ready it cannot use.
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    assign w_off = req_addr[1:0];

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_nbytes = 3'd0;
        w_load   = 1'b0;
        case (req_op)
            OP_LW:  begin w_nbytes = 3'd4; w_load = 1'b1; end
            OP_LHU: begin w_nbytes = 3'd2; w_load = 1'b1; end
            OP_LH:  begin w_nbytes = 3'd2; w_load = 1'b1; end
            OP_LBU: begin w_nbytes = 3'd1; w_load = 1'b1; end
            OP_LB:  begin w_nbytes = 3'd1; w_load = 1'b1; end
            OP_SW:  w_nbytes = 3'd4;
            OP_SH:  w_nbytes = 3'd2;
            OP_SB:  w_nbytes = 3'd1;
            default: ;
        endcase
    end

    assign w_legal = (w_nbytes != 3'd0);
    assign w_misal = ((w_nbytes == 3'd4) && (w_off != 2'd0)) ||
                     ((w_nbytes == 3'd2) && w_off[0]);
    // A halfword at offset 1 ends at byte 2 and stays inside one word.
    assign w_cross = (({1'b0, w_off} + w_nbytes) > 3'd4);
    assign w_err   = !w_legal || ((SPLIT_UNALIGNED == 0) && w_misal);

    always_comb begin
        w_st_src  = `MEM_WRITE8;
        w_st_data = {{(W-8){1'b0}}, req_wdata[7:0]};
        case (w_nbytes)
            3'd4: begin
                w_st_src  = `MEM_WRITE32;
                w_st_data = req_wdata;
            end
            3'd2: begin
                w_st_src  = `MEM_WRITE16;
                w_st_data = {{(W-16){1'b0}}, req_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // Little-endian merge: byte k of the result is byte (o+k) of {word1, word0}.
    // In LD0 the current read word is the only one needed.
    assign w_cat     = (r_state == S_LD1) ? {mem_rdata, r_word0} : {{W{1'b0}}, mem_rdata};
    assign w_shifted = w_cat >> {r_addr[1:0], 3'b000};
    assign w_lo      = w_shifted[W-1:0];

    always_comb begin
        w_ld = w_lo;
        case (r_op)
            OP_LHU:  w_ld = {{(W-16){1'b0}}, w_lo[15:0]};
            OP_LH:   w_ld = {{(W-16){w_lo[15]}}, w_lo[15:0]};
            OP_LBU:  w_ld = {{(W-8){1'b0}}, w_lo[7:0]};
            OP_LB:   w_ld = {{(W-8){w_lo[7]}}, w_lo[7:0]};
            default: ;
        endcase
    end

    assign w_cnt_nxt  = r_cnt + 2'd1;
    assign w_byte_nxt = r_wdata[{w_cnt_nxt, 3'b000} +: 8];

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cross    <= 1'b0;
            r_cnt      <= 2'd0;
            r_last     <= 2'd0;
            r_word0    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_source <= `MEM_NOP;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cross <= w_cross;
                        r_cnt   <= 2'd0;
                        if (w_err) begin
                            // No memory cycle at all; respond on the next cycle.
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (w_load) begin
                            r_state    <= S_LD0;
                            mem_source <= `MEM_READ32;
                            mem_addr   <= {req_addr[W-1:2], 2'b00};
                        end else if (w_misal) begin
                            // Split store: one byte per cycle, starting at the
                            // original byte address.
                            r_state    <= S_ST;
                            r_last     <= (w_nbytes == 3'd4) ? 2'd3 : 2'd1;
                            mem_source <= `MEM_WRITE8;
                            mem_addr   <= req_addr;
                            mem_wdata  <= {{(W-8){1'b0}}, req_wdata[7:0]};
                        end else begin
                            r_state    <= S_ST;
                            r_last     <= 2'd0;
                            mem_source <= w_st_src;
                            mem_addr   <= req_addr;
                            mem_wdata  <= w_st_data;
                        end
                    end
                end

                S_LD0: begin
                    r_word0 <= mem_rdata;
                    if (r_cross) begin
                        r_state  <= S_LD1;
                        mem_addr <= mem_addr + W'(4);
                    end else begin
                        r_state    <= S_RESP;
                        mem_source <= `MEM_NOP;
                        mem_addr   <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= w_ld;
                    end
                end

                S_LD1: begin
                    r_state    <= S_RESP;
                    mem_source <= `MEM_NOP;
                    mem_addr   <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_rdata  <= w_ld;
                end

                S_ST: begin
                    if (r_cnt == r_last) begin
                        r_state    <= S_RESP;
                        mem_source <= `MEM_NOP;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= '0;
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        mem_addr  <= r_addr + {{(W-2){1'b0}}, w_cnt_nxt};
                        mem_wdata <= {{(W-8){1'b0}}, w_byte_nxt};
                    end
                end

                S_RESP: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    mem_source <= `MEM_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps

`ifndef MEM_NOP
`define MEM_NOP     4'h0
`endif
`ifndef MEM_READ8
`define MEM_READ8   4'h1
`endif
`ifndef MEM_READ16
`define MEM_READ16  4'h2
`endif
`ifndef MEM_READ32
`define MEM_READ32  4'h3
`endif
`ifndef MEM_WRITE8
`define MEM_WRITE8  4'h4
`endif
`ifndef MEM_WRITE16
`define MEM_WRITE16 4'h5
`endif
`ifndef MEM_WRITE32
`define MEM_WRITE32 4'h6
`endif

// Two units share the request bus: u0 rejects misaligned accesses, u1 splits
// them. Each has its own byte memory (256 bytes, aliased by address mod 256)
// and its own reference memory updated by the model.
module tb_mem_access_unit;

    localparam logic [3:0] LW  = 4'b0000;
    localparam logic [3:0] LHU = 4'b0001;
    localparam logic [3:0] LH  = 4'b0010;
    localparam logic [3:0] LBU = 4'b0011;
    localparam logic [3:0] LB  = 4'b0100;
    localparam logic [3:0] SW  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SB  = 4'b1011;

    typedef struct packed {
        logic [3:0]  src;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        ready;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        s_ready [2];
    logic        s_rvalid [2];
    logic [31:0] s_rdata [2];
    logic        s_err [2];
    logic [3:0]  m_src [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];

    logic [7:0]  env_mem [2][256];
    logic [7:0]  ref_mem [2][256];

    cyc_t        exp_q [2][$];
    logic        chk_on = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.SPLIT_UNALIGNED(0), .W(32)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_ready[0]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rvalid[0]), .rsp_rdata(s_rdata[0]), .rsp_err(s_err[0]),
        .mem_source(m_src[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]),
        .mem_rdata(m_rdata[0])
    );

    mem_access_unit #(.SPLIT_UNALIGNED(1), .W(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_ready[1]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rvalid[1]), .rsp_rdata(s_rdata[1]), .rsp_err(s_err[1]),
        .mem_source(m_src[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]),
        .mem_rdata(m_rdata[1])
    );

    // ---------------- memory environment ----------------
    always_comb begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                m_rdata[i][8*k +: 8] = env_mem[i][m_addr[i][7:0] + 8'(k)];
    end

    function automatic int wr_len(input logic [3:0] src);
        case (src)
            `MEM_WRITE32: return 4;
            `MEM_WRITE16: return 2;
            `MEM_WRITE8:  return 1;
            default:      return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < wr_len(m_src[i]); k++)
                env_mem[i][m_addr[i][7:0] + 8'(k)] <= m_wdata[i][8*k +: 8];
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            LW, SW:       return 4;
            LH, LHU, SH:  return 2;
            LB, LBU, SB:  return 1;
            default:      return 0;
        endcase
    endfunction

    function automatic bit model_misal(input logic [3:0] op, input logic [31:0] addr);
        int s = op_size(op);
        int o = int'(addr[1:0]);
        return (s == 4 && o != 0) || (s == 2 && (o % 2) == 1);
    endfunction

    // Unit 0 does not split, so any misaligned access is an error there.
    function automatic bit model_err(input int inst, input logic [3:0] op, input logic [31:0] addr);
        return (op_size(op) == 0) || (inst == 0 && model_misal(op, addr));
    endfunction

    function automatic logic [31:0] model_load(input int inst, input logic [3:0] op,
                                               input logic [31:0] addr);
        logic [31:0] v = '0;
        for (int k = 0; k < op_size(op); k++)
            v[8*k +: 8] = ref_mem[inst][addr[7:0] + 8'(k)];
        if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic void ref_store(input int inst, input logic [31:0] addr,
                                      input logic [31:0] data, input int nbytes);
        for (int k = 0; k < nbytes; k++)
            ref_mem[inst][addr[7:0] + 8'(k)] = data[8*k +: 8];
    endfunction

    function automatic cyc_t mk(input logic [3:0] src, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] wmask,
                                input logic rvalid, input logic [31:0] rdata, input logic err);
        cyc_t e;
        e.src = src; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        e.rvalid = rvalid; e.rdata = rdata; e.err = err; e.ready = 1'b0;
        return e;
    endfunction

    // Pushes the expected output of every cycle from the one after the accept
    // edge up to the response; returns the latency in cycles.
    function automatic int plan(input int inst, input logic [3:0] op,
                                input logic [31:0] addr, input logic [31:0] wd);
        int s = op_size(op);
        int o = int'(addr[1:0]);
        bit err = model_err(inst, op, addr);
        bit load = (op[3] == 1'b0);
        logic [31:0] base = addr & 32'hFFFF_FFFC;
        logic [31:0] rd = '0;
        int n = 0;
        if (!err) begin
            if (load) begin
                exp_q[inst].push_back(mk(`MEM_READ32, base, '0, '0, 1'b0, '0, 1'b0)); n++;
                if (o + s > 4) begin
                    exp_q[inst].push_back(mk(`MEM_READ32, base + 32'd4, '0, '0, 1'b0, '0, 1'b0)); n++;
                end
                rd = model_load(inst, op, addr);
            end else if (model_misal(op, addr)) begin
                for (int i = 0; i < s; i++) begin
                    exp_q[inst].push_back(mk(`MEM_WRITE8, addr + 32'(i), 32'(wd[8*i +: 8]),
                                             32'h0000_00FF, 1'b0, '0, 1'b0));
                    n++;
                end
            end else begin
                case (s)
                    4: exp_q[inst].push_back(mk(`MEM_WRITE32, addr, wd, 32'hFFFF_FFFF, 1'b0, '0, 1'b0));
                    2: exp_q[inst].push_back(mk(`MEM_WRITE16, addr, wd, 32'h0000_FFFF, 1'b0, '0, 1'b0));
                    default: exp_q[inst].push_back(mk(`MEM_WRITE8, addr, wd, 32'h0000_00FF, 1'b0, '0, 1'b0));
                endcase
                n++;
            end
        end
        exp_q[inst].push_back(mk(`MEM_NOP, '0, '0, '0, 1'b1, rd, err)); n++;
        return n;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cyc_t e;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                end else begin
                    e = mk(`MEM_NOP, '0, '0, '0, 1'b0, '0, 1'b0);
                    e.ready = !rst;
                end
                check($sformatf("u%0d mem_source", i), 32'(m_src[i]), 32'(e.src));
                if (e.src != `MEM_NOP)
                    check($sformatf("u%0d mem_addr", i), m_addr[i], e.addr);
                if (e.wmask != 32'h0)
                    check($sformatf("u%0d mem_wdata", i), m_wdata[i] & e.wmask, e.wdata & e.wmask);
                check($sformatf("u%0d rsp_valid", i), 32'(s_rvalid[i]), 32'(e.rvalid));
                if (e.rvalid) begin
                    check($sformatf("u%0d rsp_rdata", i), s_rdata[i], e.rdata);
                    check($sformatf("u%0d rsp_err", i), 32'(s_err[i]), 32'(e.err));
                end
                check($sformatf("u%0d req_ready", i), 32'(s_ready[i]), 32'(e.ready));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout actual=%0d required=<40 cycles", n);
            exp_q[0].delete();
            exp_q[1].delete();
        end
    endtask

    // lat0/lat1 < 0 means no hand-computed latency for that unit.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat0, input int lat1);
        int l0;
        int l1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        l0 = plan(0, op, addr, wd);
        l1 = plan(1, op, addr, wd);
        if (lat0 >= 0) check("u0 latency", 32'(l0), 32'(lat0));
        if (lat1 >= 0) check("u1 latency", 32'(l1), 32'(lat1));
        #1 req_valid = 1'b0;
        if (op[3]) begin
            for (int i = 0; i < 2; i++)
                if (!model_err(i, op, addr)) ref_store(i, addr, wd, op_size(op));
        end
        wait_drain();
    endtask

    task automatic preload();
        logic [63:0] init = 64'h8877_6655_4433_2211;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) begin
                env_mem[i][8'h10 + 8'(k)] = init[8*k +: 8];
                ref_mem[i][8'h10 + 8'(k)] = init[8*k +: 8];
            end
    endtask

    logic [3:0]  ops [10];
    logic [31:0] rnd_addr;
    int          sel;

    initial begin
        ops = '{LW, LHU, LH, LBU, LB, SW, SH, SB, 4'b0111, 4'b1010};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++) begin
                env_mem[i][j] = 8'(j) ^ 8'h5A;
                ref_mem[i][j] = 8'(j) ^ 8'h5A;
            end
        preload();

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d reset req_ready", i), 32'(s_ready[i]), 32'd0);
            check($sformatf("u%0d reset mem_source", i), 32'(m_src[i]), 32'(`MEM_NOP));
            check($sformatf("u%0d reset rsp_valid", i), 32'(s_rvalid[i]), 32'd0);
            check($sformatf("u%0d reset rsp_rdata", i), s_rdata[i], 32'd0);
            check($sformatf("u%0d reset rsp_err", i), 32'(s_err[i]), 32'd0);
            check($sformatf("u%0d reset mem_addr", i), m_addr[i], 32'd0);
            check($sformatf("u%0d reset mem_wdata", i), m_wdata[i], 32'd0);
        end
        rst    = 1'b0;
        chk_on = 1'b1;

        // Hand-computed values that pin the model.
        check("pin LW 10",  model_load(1, LW,  32'h10), 32'h4433_2211);
        check("pin LB 17",  model_load(1, LB,  32'h17), 32'hFFFF_FF88);
        check("pin LBU 17", model_load(1, LBU, 32'h17), 32'h0000_0088);
        check("pin LH 16",  model_load(1, LH,  32'h16), 32'hFFFF_8877);
        check("pin LHU 11", model_load(1, LHU, 32'h11), 32'h0000_3322);
        check("pin LW 13",  model_load(1, LW,  32'h13), 32'h7766_5544);

        do_req(LW,  32'h10, '0, 2, 2);
        do_req(LB,  32'h17, '0, 2, 2);
        do_req(LBU, 32'h17, '0, 2, 2);
        do_req(LH,  32'h16, '0, 2, 2);
        do_req(LHU, 32'h11, '0, 1, 2);
        do_req(LW,  32'h13, '0, 1, 3);
        do_req(LH,  32'h11, '0, 1, 2);
        do_req(4'b0111, 32'h10, '0, 1, 1);
        do_req(4'b1010, 32'h10, 32'h1234_5678, 1, 1);

        // Reset two cycles into a split SW: bytes 0x15 and 0x16 land, 0x17 does not.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h15;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        void'(plan(0, SW, 32'h15, 32'hDEAD_BEEF));
        void'(plan(1, SW, 32'h15, 32'hDEAD_BEEF));
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_q[0].delete();
        exp_q[1].delete();
        #1 rst = 1'b0;
        ref_store(1, 32'h15, 32'hDEAD_BEEF, 2);
        repeat (3) @(negedge clk);
        check("rst byte 15", 32'(env_mem[1][8'h15]), 32'h0000_00EF);
        check("rst byte 16", 32'(env_mem[1][8'h16]), 32'h0000_00BE);
        check("rst byte 17", 32'(env_mem[1][8'h17]), 32'h0000_0088);

        // Full split SW on fresh contents.
        preload();
        do_req(SW, 32'h15, 32'hDEAD_BEEF, 1, 5);
        check("sw word 14", {env_mem[1][8'h17], env_mem[1][8'h16], env_mem[1][8'h15], env_mem[1][8'h14]},
              32'hADBE_EF55);
        check("sw byte 18", 32'(env_mem[1][8'h18]), 32'h0000_00DE);
        check("pin LW 14", model_load(1, LW, 32'h14), 32'hADBE_EF55);
        do_req(LW, 32'h14, '0, 2, 2);

        // Sub-word stores and wrap-around boundaries.
        do_req(SH, 32'h13, 32'h0000_CAFE, 1, 3);
        do_req(SH, 32'h12, 32'hFFFF_1357, 2, 2);
        do_req(SB, 32'h11, 32'hFFFF_FFA5, 2, 2);
        do_req(LW, 32'h10, '0, 2, 2);
        do_req(SW, 32'hFFFF_FFFE, 32'h0BAD_F00D, 1, 5);
        do_req(LW, 32'hFFFF_FFFD, '0, 1, 3);
        do_req(LH, 32'hFFFF_FFFF, '0, 1, 3);

        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      rnd_addr = 32'($urandom_range(0, 63));
            else if (sel < 9) rnd_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else              rnd_addr = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(ops[$urandom_range(0, 9)], rnd_addr, $urandom, -1, -1);
        end

        chk_on = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                check($sformatf("u%0d final byte %0h", i, j), 32'(env_mem[i][j]), 32'(ref_mem[i][j]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
